bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
Round-robin arbiter that shares one single-port block-RAM buffer (1-cycle registered read latency, read-first) between a write client and a read client.
Each client uses a valid/ready request handshake. The arbiter drives the BRAM we/addr/din pins and returns read data with a response-valid strobe.
It sits between the producer/consumer engines and the on-chip buffer bank, and keeps a saturating conflict counter for performance monitoring.

Parameters:
WIDTH, 64, data word width in bits (N * DW); must match the attached buffer.
DEPTH, 256, buffer depth in words; local AW = $clog2(DEPTH).
CNT_W, 16, width of the saturating conflict counter.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  write request pending
wr_ready  out  1  write request granted this cycle
wr_addr  in  AW  write address
wr_data  in  WIDTH  write data
rd_valid  in  1  read request pending
rd_ready  out  1  read request granted this cycle
rd_addr  in  AW  read address
rd_resp_valid  out  1  rd_resp_data valid this cycle (no backpressure)
rd_resp_data  out  WIDTH  read data returned
bram_we  out  1  to buffer we
bram_addr  out  AW  to buffer addr
bram_din  out  WIDTH  to buffer din
bram_dout  in  WIDTH  from buffer dout
conflict_cnt  out  CNT_W  cycles with wr_valid & rd_valid both high, saturating

Behaviour:
- State: rr_last (1 bit, 0 = write served last, 1 = read served last), rd_pend (1 bit), conflict_cnt.
- Reset (rst_n low, async): rr_last=1, rd_pend=0, conflict_cnt=0.
  - While rst_n is low, wr_ready, rd_ready, bram_we and rd_resp_valid are forced to 0.
  - rd_resp_data is don't-care.
- Grant (combinational, same cycle as request):
  - only wr_valid -> grant write
  - only rd_valid -> grant read
  - both -> grant the side NOT equal to rr_last
  - neither -> no grant
- At most one grant per cycle; wr_ready and rd_ready are never both 1.
- Transfer occurs when valid & ready. A client must hold valid, addr and data stable until ready. The arbiter never retracts a grant within a cycle.
- rr_last updates on every granted cycle: to 0 on a write grant, to 1 on a read grant. It holds on idle cycles.
- BRAM drive:
  - bram_we = write grant.
  - bram_addr = wr_addr on a write grant, otherwise rd_addr (also when idle).
  - bram_din = wr_data at all times.
- Read latency:
  - rd_pend <= read grant (registered).
  - rd_resp_valid = rd_pend.
  - rd_resp_data = bram_dout (combinational pass-through).
  - Net: the response arrives exactly 1 cycle after the rd_valid & rd_ready cycle.
- Back-to-back reads sustain 1 response per cycle.
- BRAM dout during a write cycle (read-first old data) is never flagged valid.
- Write then read of the same address in consecutive grants: the read returns the new data. Reads and writes never share a cycle.
- Fairness: under continuous contention, grants alternate W, R, W, R, ... Max wait for either client is 1 cycle.
- conflict_cnt increments by 1 on every cycle with wr_valid & rd_valid, saturates at 2^CNT_W-1, and cleared only by reset.
- Reset asserted mid-read: the pending response is dropped (rd_resp_valid = 0 immediately, async). After release, the first contention grants write (rr_last=1).

Test Plan:
- Reset release, wr_valid=1, addr=5, data=0xA5A5 -> wr_ready=1, bram_we=1, bram_addr=5 the same cycle; rd_ready=0.
- Read addr 5 on the next cycle -> rd_ready=1, bram_we=0; next cycle rd_resp_valid=1, rd_resp_data=0xA5A5.
- Both clients valid for 6 cycles from reset -> grant sequence W,R,W,R,W,R. conflict_cnt=6. Each rd_resp_valid lags its read grant by exactly 1 cycle.
- Continuous reads of addrs 0..7 with no writer -> rd_ready high 8 consecutive cycles; responses on 8 consecutive cycles in address order.
- CNT_W=4, 20 contention cycles -> conflict_cnt stops at 15 and stays 15.
- Assert rst_n low in the cycle after a read grant -> rd_resp_valid=0 immediately. After release with both valid, the first grant is write.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Client-side request/response bundle for the BRAM port arbiter.
// master = the producer/consumer engines, slave = the arbiter.
interface bram_port_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int AW    = 8
);
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [AW-1:0]    rd_addr;
  logic             rd_resp_valid;
  logic [WIDTH-1:0] rd_resp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_data
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin share of one single-port read-first BRAM between a write client
// and a read client, with a saturating contention counter.
module bram_port_arbiter #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 256,
  parameter  int CNT_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_port_arbiter_if.slave  cli,
  output logic                bram_we,
  output logic [AW-1:0]       bram_addr,
  output logic [WIDTH-1:0]    bram_din,
  input  logic [WIDTH-1:0]    bram_dout,
  output logic [CNT_W-1:0]    conflict_cnt
);
  logic rr_last;  // 1 = read was served last
  logic rd_pend;
  logic both;
  logic gnt_w;
  logic gnt_r;

  // Grants are combinational so a lone requester is served the cycle it asks.
  always_comb begin
    both  = cli.wr_valid & cli.rd_valid;
    gnt_w = 1'b0;
    gnt_r = 1'b0;
    if (rst_n) begin
      if (both) begin
        gnt_w = rr_last;
        gnt_r = ~rr_last;
      end else begin
        gnt_w = cli.wr_valid;
        gnt_r = cli.rd_valid;
      end
    end
  end

  assign cli.wr_ready      = gnt_w;
  assign cli.rd_ready      = gnt_r;
  assign bram_we           = gnt_w;
  assign bram_addr         = gnt_w ? cli.wr_addr : cli.rd_addr;
  assign bram_din          = cli.wr_data;
  // Only read-grant cycles flag dout, so read-first stale data is never seen.
  assign cli.rd_resp_valid = rd_pend;
  assign cli.rd_resp_data  = bram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last      <= 1'b1;
      rd_pend      <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (gnt_w)      rr_last <= 1'b0;
      else if (gnt_r) rr_last <= 1'b1;
      rd_pend <= gnt_r;
      if (both && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized self-checking bench for bram_port_arbiter against a behavioural
// model of the arbitration rules and a read-first BRAM.
module tb_bram_port_arbiter;
  localparam int WIDTH = 64;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             wr_valid = 1'b0, rd_valid = 1'b0;
  logic [AW-1:0]    wr_addr = '0, rd_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;

  bram_port_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  bram_port_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus4 ();
  assign bus.wr_valid  = wr_valid;  assign bus4.wr_valid = wr_valid;
  assign bus.rd_valid  = rd_valid;  assign bus4.rd_valid = rd_valid;
  assign bus.wr_addr   = wr_addr;   assign bus4.wr_addr  = wr_addr;
  assign bus.rd_addr   = rd_addr;   assign bus4.rd_addr  = rd_addr;
  assign bus.wr_data   = wr_data;   assign bus4.wr_data  = wr_data;

  logic             bram_we, bram_we4;
  logic [AW-1:0]    bram_addr, bram_addr4;
  logic [WIDTH-1:0] bram_din, bram_din4, bram_dout;
  logic [15:0]      conflict_cnt;
  logic [3:0]       cnt4;

  bram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cli(bus.slave), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout), .conflict_cnt(conflict_cnt));
  bram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cli(bus4.slave), .bram_we(bram_we4), .bram_addr(bram_addr4),
    .bram_din(bram_din4), .bram_dout({WIDTH{1'b0}}), .conflict_cnt(cnt4));

  // Single-port read-first BRAM with one cycle registered read.
  logic [WIDTH-1:0] bram_mem [DEPTH];
  always @(posedge clk) begin
    if (bram_we) bram_mem[bram_addr] <= bram_din;
    bram_dout <= bram_mem[bram_addr];
  end

  // Reference model: who was served last, expected response, contention count.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic             m_last_rd;
  logic             m_pend;
  logic [WIDTH-1:0] m_rdata;
  int               m_cnt;

  function automatic logic exp_w();
    if (!rst_n || !wr_valid) return 1'b0;
    if (rd_valid) return m_last_rd;  // contention: whoever was not served last
    return 1'b1;
  endfunction
  function automatic logic exp_r();
    if (!rst_n || !rd_valid) return 1'b0;
    if (wr_valid) return !m_last_rd;
    return 1'b1;
  endfunction
  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last_rd <= 1'b1;
      m_pend    <= 1'b0;
      m_cnt     <= 0;
    end else begin
      if (exp_w()) ref_mem[wr_addr] <= wr_data;
      if (exp_r()) m_rdata <= ref_mem[rd_addr];
      m_pend <= exp_r();
      if (exp_w()) m_last_rd <= 1'b0;
      else if (exp_r()) m_last_rd <= 1'b1;
      if (wr_valid && rd_valid) m_cnt <= m_cnt + 1;
    end
  end

  int total = 0;
  int pass  = 0;

  task automatic apply_reset();
    wr_valid = 1'b0; rd_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 8'd3; rd_addr = 8'd4;
    @(negedge clk); #1;
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL reset wr_ready got %b want 0", bus.wr_ready); else pass++;
    total++; if (bus.rd_ready !== 1'b0) $display("FAIL reset rd_ready got %b want 0", bus.rd_ready); else pass++;
    total++; if (bram_we !== 1'b0) $display("FAIL reset bram_we got %b want 0", bram_we); else pass++;
    total++; if (bus.rd_resp_valid !== 1'b0) $display("FAIL reset rd_resp_valid got %b want 0", bus.rd_resp_valid); else pass++;
    total++; if (conflict_cnt !== 16'd0) $display("FAIL reset conflict_cnt got %0d want 0", conflict_cnt); else pass++;
    apply_reset();
  endtask

  task automatic test_write_read();
    @(negedge clk); wr_valid = 1'b1; wr_addr = 8'd5; wr_data = 64'hA5A5; rd_valid = 1'b0; #1;
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL wr wr_ready got %b want 1", bus.wr_ready); else pass++;
    total++; if (bram_we !== 1'b1) $display("FAIL wr bram_we got %b want 1", bram_we); else pass++;
    total++; if (bram_addr !== 8'd5) $display("FAIL wr bram_addr got %0d want 5", bram_addr); else pass++;
    total++; if (bram_din !== 64'hA5A5) $display("FAIL wr bram_din got %h want a5a5", bram_din); else pass++;
    total++; if (bus.rd_ready !== 1'b0) $display("FAIL wr rd_ready got %b want 0", bus.rd_ready); else pass++;
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 8'd5; #1;
    total++; if (bus.rd_ready !== 1'b1) $display("FAIL rd rd_ready got %b want 1", bus.rd_ready); else pass++;
    total++; if (bram_we !== 1'b0) $display("FAIL rd bram_we got %b want 0", bram_we); else pass++;
    total++; if (bram_addr !== 8'd5) $display("FAIL rd bram_addr got %0d want 5", bram_addr); else pass++;
    @(negedge clk); rd_valid = 1'b0; #1;
    total++; if (bus.rd_resp_valid !== 1'b1) $display("FAIL rd resp_valid got %b want 1", bus.rd_resp_valid); else pass++;
    total++; if (bus.rd_resp_data !== 64'hA5A5) $display("FAIL rd resp_data got %h want a5a5", bus.rd_resp_data); else pass++;
  endtask

  task automatic test_contention();
    apply_reset();
    wr_addr = 8'd20; rd_addr = 8'd20; wr_data = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); wr_valid = 1'b1; rd_valid = 1'b1; #1;
      total++; if (bus.wr_ready !== (i % 2 == 0)) $display("FAIL contend wr_ready cyc %0d got %b", i, bus.wr_ready); else pass++;
      total++; if (bus.rd_ready !== (i % 2 == 1)) $display("FAIL contend rd_ready cyc %0d got %b", i, bus.rd_ready); else pass++;
      total++; if (bus.rd_resp_valid !== (i > 0 && (i - 1) % 2 == 1))
        $display("FAIL contend resp_valid cyc %0d got %b", i, bus.rd_resp_valid); else pass++;
      if (bus.rd_resp_valid === 1'b1) begin
        total++; if (bus.rd_resp_data !== 64'h1234_5678_9ABC_DEF0)
          $display("FAIL contend resp_data cyc %0d got %h want 123456789abcdef0", i, bus.rd_resp_data); else pass++;
      end
    end
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b0; #1;
    total++; if (conflict_cnt !== 16'd6) $display("FAIL contend conflict_cnt got %0d want 6", conflict_cnt); else pass++;
    total++; if (bus.rd_resp_valid !== 1'b1) $display("FAIL contend last resp_valid got %b want 1", bus.rd_resp_valid); else pass++;
  endtask

  task automatic test_random();
    logic wg = 1'b1, rg = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      // Requests only change once granted or when idle.
      if (!wr_valid || wg) begin
        wr_valid = ($urandom_range(0, 2) != 0); wr_addr = 8'($urandom_range(0, 15));
        wr_data = {$urandom, $urandom};
      end
      if (!rd_valid || rg) begin
        rd_valid = ($urandom_range(0, 2) != 0); rd_addr = 8'($urandom_range(0, 15));
      end
      #1;
      wg = exp_w(); rg = exp_r();
      total++; if (bus.wr_ready !== wg) $display("FAIL rnd wr_ready cyc %0d got %b want %b", i, bus.wr_ready, wg); else pass++;
      total++; if (bus.rd_ready !== rg) $display("FAIL rnd rd_ready cyc %0d got %b want %b", i, bus.rd_ready, rg); else pass++;
      total++; if (bram_addr !== (wg ? wr_addr : rd_addr))
        $display("FAIL rnd bram_addr cyc %0d got %0d want %0d", i, bram_addr, wg ? wr_addr : rd_addr); else pass++;
      total++; if (bus.rd_resp_valid !== m_pend)
        $display("FAIL rnd resp_valid cyc %0d got %b want %b", i, bus.rd_resp_valid, m_pend); else pass++;
      if (m_pend) begin
        total++; if (bus.rd_resp_data !== m_rdata)
          $display("FAIL rnd resp_data cyc %0d got %h want %h", i, bus.rd_resp_data, m_rdata); else pass++;
      end
      total++; if (conflict_cnt !== 16'(sat(m_cnt, 65535)))
        $display("FAIL rnd conflict_cnt cyc %0d got %0d want %0d", i, conflict_cnt, sat(m_cnt, 65535)); else pass++;
    end
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); wr_valid = 1'b1; rd_valid = 1'b0; wr_addr = 8'(i); wr_data = {$urandom, $urandom};
    end
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk); wr_valid = 1'b0; rd_valid = (i < 8); rd_addr = 8'(i % 8); #1;
      if (i < 8) begin
        total++; if (bus.rd_ready !== 1'b1) $display("FAIL b2b rd_ready cyc %0d got %b want 1", i, bus.rd_ready); else pass++;
      end
      if (i > 0) begin
        total++; if (bus.rd_resp_valid !== 1'b1) $display("FAIL b2b resp_valid cyc %0d got %b want 1", i, bus.rd_resp_valid); else pass++;
        total++; if (bus.rd_resp_data !== ref_mem[i-1])
          $display("FAIL b2b resp_data addr %0d got %h want %h", i - 1, bus.rd_resp_data, ref_mem[i-1]); else pass++;
      end
    end
    rd_valid = 1'b0;
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk); wr_valid = (i < 20); rd_valid = (i < 20); #1;
      total++; if (cnt4 !== 4'(sat(i, 15))) $display("FAIL sat cnt4 cyc %0d got %0d want %0d", i, cnt4, sat(i, 15)); else pass++;
    end
    total++; if (conflict_cnt !== 16'd20) $display("FAIL sat conflict_cnt got %0d want 20", conflict_cnt); else pass++;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 8'd2; #1;
    total++; if (bus.rd_ready !== 1'b1) $display("FAIL midrst rd_ready got %b want 1", bus.rd_ready); else pass++;
    @(negedge clk); rd_valid = 1'b0; #1;
    total++; if (bus.rd_resp_valid !== 1'b1) $display("FAIL midrst pre resp_valid got %b want 1", bus.rd_resp_valid); else pass++;
    #1 rst_n = 1'b0; wr_valid = 1'b1; #1;
    total++; if (bus.rd_resp_valid !== 1'b0) $display("FAIL midrst resp_valid got %b want 0", bus.rd_resp_valid); else pass++;
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL midrst wr_ready got %b want 0", bus.wr_ready); else pass++;
    @(negedge clk); rst_n = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; #1;
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL midrst first wr_ready got %b want 1", bus.wr_ready); else pass++;
    total++; if (bus.rd_ready !== 1'b0) $display("FAIL midrst first rd_ready got %b want 0", bus.rd_ready); else pass++;
    @(negedge clk); wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      bram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    m_rdata = '0;
    test_reset();
    test_write_read();
    test_contention();
    test_random();
    test_back_to_back();
    test_saturate();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
